id_stage: RTL
=============

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter NREG, default 8: number of general registers, indexed by 3-bit fields.
REQ-002 SHALL have parameter NOP_IR, default 16'h0000: bubble instruction word.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port state  input  1  pipeline advances only when equal to exec code from shared define file.
REQ-006 SHALL have port id_ir  input  16  instruction from fetch stage.
REQ-007 SHALL have ports wb_we/wb_addr/wb_data  input  1/3/16  register write-back request, address, data.
REQ-008 SHALL have port flush  input  1  taken branch/jump resolved downstream; kill instruction in decode.
REQ-009 SHALL have port ex_ir  output  16  instruction passed to execute stage.
REQ-010 SHALL have ports reg_A, reg_B, smdr  output  16 each  operand A, operand B, store data.
REQ-011 SHALL have port stall  output  1  load-use hazard; fetch stage holds pc and id_ir.

Function
REQ-012 SHALL hold register file gr[0..7] x 16 bits; all eight writable, no hardwired zero.
REQ-013 SHALL write gr[wb_addr] <= wb_data on rising edge when wb_we=1 and state=exec.
REQ-014 SHALL bypass write-back combinationally: any read whose index equals wb_addr while wb_we=1 returns wb_data, not stale gr.
REQ-015 SHALL decode fields: op=id_ir[15:11], r1=id_ir[10:8], r2=id_ir[6:4], r3=id_ir[2:0], val2=id_ir[3:0], val3=id_ir[7:0].
REQ-016 SHALL select reg_A = gr[r1] for ADDI, SUBI, LDIH, JMPR and all conditional branches; gr[r2] otherwise.
REQ-017 SHALL select reg_B = {8'h00,val3} for ADDI, SUBI, JMPR, branches; {val3,8'h00} for LDIH; {12'h000,val2} for LOAD, STORE, shifts; gr[r3] for register-register ALU ops; 16'h0000 for NOP, HALT, JUMP.
REQ-018 SHALL drive smdr = gr[r1] for STORE, 16'h0000 otherwise.
REQ-019 SHALL register ex_ir, reg_A, reg_B, smdr on rising edge when state=exec: one-cycle latency from id_ir to outputs.
REQ-020 SHALL assert stall combinationally when ex_ir op is LOAD and ex_ir[10:8] equals any register source id_ir actually reads (per REQ-016..018).
REQ-021 SHALL, on a stalled exec edge, load ex_ir <= NOP_IR and reg_A/reg_B/smdr <= 0, while register file writes still occur.
REQ-022 SHALL, on an exec edge with flush=1, load bubble as in REQ-021; flush has priority over stall; stall forced 0 when flush=1.
REQ-023 SHALL hold all outputs and register file unchanged when state is not exec, regardless of flush, stall or wb_we.
REQ-024 SHALL treat undefined opcodes as register-register form (REQ-017 gr[r3]), passing id_ir unchanged.
REQ-025 SHALL implement all widths exactly; no sign extension of val2/val3.

Reset
REQ-026 SHALL, on reset low, immediately clear ex_ir, reg_A, reg_B, smdr to 16'h0000 and all gr to 16'h0000, independent of clock.
REQ-027 SHALL, with ex_ir cleared (NOP), deassert stall during and after reset.
REQ-028 SHALL, on reset asserted mid-operation, discard in-flight write-back; first exec edge after release behaves as from power-up.

Verification
REQ-029 SHALL cover write-back then read: wb gr3=16'h1234; next cycle ADD r1,r2=3,r3=3 -> reg_A=reg_B=16'h1234.
REQ-030 SHALL cover same-cycle bypass: wb_we=1, wb_addr=5, wb_data=16'hBEEF with id_ir reading gr5 as r2 -> reg_A=16'hBEEF after edge.
REQ-031 SHALL cover immediates: ADDI r1=2, val3=8'hF0 -> reg_B=16'h00F0; LDIH val3=8'hAB -> reg_B=16'hAB00; LOAD val2=4'h7 -> reg_B=16'h0007.
REQ-032 SHALL cover load-use: ex_ir=LOAD r1=4, id_ir=SUB r2=4 -> stall=1, next ex_ir=16'h0000; following cycle SUB issues with stall=0.
REQ-033 SHALL cover flush priority: flush=1 and stall=1 same cycle -> stall=0, ex_ir=16'h0000; state=idle with flush=1 -> outputs unchanged.
REQ-034 SHALL cover async reset: reset low between edges with gr nonzero -> outputs and all gr read 16'h0000 immediately.

Source files
------------

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage : instruction decode stage with an 8 x 16 general register file.
//
// Ports
//   clock, reset         rising-edge clock, asynchronous active-low reset
//   state                pipeline advances only when equal to STATE_EXEC
//   id_ir                instruction word from fetch
//   wb_we/wb_addr/wb_data register write-back request (bypassed to reads)
//   flush                kill the instruction currently in decode
//   ex_ir                instruction word handed to execute
//   reg_A, reg_B, smdr   operand A, operand B, store data
//   stall                load-use hazard; fetch holds pc and id_ir
// ---------------------------------------------------------------------------
module id_stage #(
  parameter int          NREG   = 8,
  parameter logic [15:0] NOP_IR = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        state,
  input  logic [15:0] id_ir,
  input  logic        wb_we,
  input  logic [2:0]  wb_addr,
  input  logic [15:0] wb_data,
  input  logic        flush,
  output logic [15:0] ex_ir,
  output logic [15:0] reg_A,
  output logic [15:0] reg_B,
  output logic [15:0] smdr,
  output logic        stall
);

  localparam logic STATE_EXEC = 1'b1;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_HALT  = 5'b00001;
  localparam logic [4:0] OP_LOAD  = 5'b00010;
  localparam logic [4:0] OP_STORE = 5'b00011;
  localparam logic [4:0] OP_SLL   = 5'b00100;
  localparam logic [4:0] OP_SLA   = 5'b00101;
  localparam logic [4:0] OP_SRL   = 5'b00110;
  localparam logic [4:0] OP_SRA   = 5'b00111;
  localparam logic [4:0] OP_ADDI  = 5'b01001;
  localparam logic [4:0] OP_SUBI  = 5'b01011;
  localparam logic [4:0] OP_LDIH  = 5'b10000;
  localparam logic [4:0] OP_JUMP  = 5'b11000;
  localparam logic [4:0] OP_JMPR  = 5'b11001;
  localparam logic [4:0] OP_BZ    = 5'b11010;
  localparam logic [4:0] OP_BNZ   = 5'b11011;
  localparam logic [4:0] OP_BN    = 5'b11100;
  localparam logic [4:0] OP_BNN   = 5'b11101;
  localparam logic [4:0] OP_BC    = 5'b11110;
  localparam logic [4:0] OP_BNC   = 5'b11111;

  logic [15:0] gr_q [NREG];
  logic [15:0] gr_d [NREG];
  logic [15:0] ex_ir_q, ex_ir_d;
  logic [15:0] reg_a_q, reg_a_d;
  logic [15:0] reg_b_q, reg_b_d;
  logic [15:0] smdr_q,  smdr_d;

  logic [4:0]  op;
  logic [2:0]  r1, r2, r3;
  logic [3:0]  val2;
  logic [7:0]  val3;
  logic [15:0] rd_r1, rd_r2, rd_r3;
  logic [15:0] opnd_a, opnd_b, opnd_s;
  logic        a_from_r1, b_from_r3, s_from_r1;
  logic [2:0]  a_idx;
  logic        stall_int;

  assign op   = id_ir[15:11];
  assign r1   = id_ir[10:8];
  assign r2   = id_ir[6:4];
  assign r3   = id_ir[2:0];
  assign val2 = id_ir[3:0];
  assign val3 = id_ir[7:0];

  // Write-back data is forwarded so a read in the same cycle sees it.
  always_comb begin
    rd_r1 = (wb_we && (wb_addr == r1)) ? wb_data : gr_q[r1];
    rd_r2 = (wb_we && (wb_addr == r2)) ? wb_data : gr_q[r2];
    rd_r3 = (wb_we && (wb_addr == r3)) ? wb_data : gr_q[r3];
  end

  always_comb begin
    a_from_r1 = 1'b0;
    b_from_r3 = 1'b0;
    s_from_r1 = 1'b0;
    opnd_b    = 16'h0000;
    case (op)
      OP_ADDI, OP_SUBI, OP_JMPR,
      OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC: begin
        a_from_r1 = 1'b1;
        opnd_b    = {8'h00, val3};
      end
      OP_LDIH: begin
        a_from_r1 = 1'b1;
        opnd_b    = {val3, 8'h00};
      end
      OP_LOAD, OP_SLL, OP_SLA, OP_SRL, OP_SRA: begin
        opnd_b = {12'h000, val2};
      end
      OP_STORE: begin
        s_from_r1 = 1'b1;
        opnd_b    = {12'h000, val2};
      end
      OP_NOP, OP_HALT, OP_JUMP: begin
        opnd_b = 16'h0000;
      end
      // Register-register ALU ops and any undefined opcode.
      default: begin
        b_from_r3 = 1'b1;
        opnd_b    = rd_r3;
      end
    endcase
    a_idx  = a_from_r1 ? r1 : r2;
    opnd_a = a_from_r1 ? rd_r1 : rd_r2;
    opnd_s = s_from_r1 ? rd_r1 : 16'h0000;
  end

  // Load-use hazard only against registers the decoded instruction reads.
  always_comb begin
    stall_int = 1'b0;
    if (!flush && (ex_ir_q[15:11] == OP_LOAD)) begin
      stall_int = (ex_ir_q[10:8] == a_idx)
               || (b_from_r3 && (ex_ir_q[10:8] == r3))
               || (s_from_r1 && (ex_ir_q[10:8] == r1));
    end
  end

  always_comb begin
    ex_ir_d = ex_ir_q;
    reg_a_d = reg_a_q;
    reg_b_d = reg_b_q;
    smdr_d  = smdr_q;
    gr_d    = gr_q;
    if (state == STATE_EXEC) begin
      if (flush || stall_int) begin
        ex_ir_d = NOP_IR;
        reg_a_d = 16'h0000;
        reg_b_d = 16'h0000;
        smdr_d  = 16'h0000;
      end else begin
        ex_ir_d = id_ir;
        reg_a_d = opnd_a;
        reg_b_d = opnd_b;
        smdr_d  = opnd_s;
      end
      // Write-back proceeds even when decode is bubbled.
      if (wb_we) begin
        gr_d[wb_addr] = wb_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_ir_q <= 16'h0000;
      reg_a_q <= 16'h0000;
      reg_b_q <= 16'h0000;
      smdr_q  <= 16'h0000;
      for (int i = 0; i < NREG; i++) begin
        gr_q[i] <= 16'h0000;
      end
    end else begin
      ex_ir_q <= ex_ir_d;
      reg_a_q <= reg_a_d;
      reg_b_q <= reg_b_d;
      smdr_q  <= smdr_d;
      gr_q    <= gr_d;
    end
  end

  assign ex_ir = ex_ir_q;
  assign reg_A = reg_a_q;
  assign reg_B = reg_b_q;
  assign smdr  = smdr_q;
  assign stall = stall_int;

endmodule
